ads1672_sample_averager: RTL and testbench

Downstream stage of the ADS1672 ADC controller. Paces acquisitions by issuing one-cycle `measure` pulses at a programmed interval. Consumes each 24-bit two's-complement sample the controller returns and block-averages 2^LOG2_AVG samples into one result. Each result also carries the min/max seen over its block, and is presented to the host-side logic on a valid/ready interface.

---
 rtl/ads1672_sample_averager.sv | 190 +++++++++++++++++++
 tb/tb_ads1672_sample_averager.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ads1672_sample_averager.sv
// Paces ADS1672 acquisitions and block-averages 2^LOG2_AVG samples into one
// result carrying the block min/max, presented on a valid/ready interface.
module ads1672_sample_averager #(
  parameter int unsigned DATA_WIDTH     = 24,
  parameter int unsigned LOG2_AVG       = 4,
  parameter int unsigned PERIOD_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    measure,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic [DATA_WIDTH-1:0]   avg_data,
  output logic [DATA_WIDTH-1:0]   avg_min,
  output logic [DATA_WIDTH-1:0]   avg_max,
  output logic                    avg_valid,
  input  logic                    avg_ready,
  output logic                    overrun,
  output logic                    timeout,
  input  logic                    clear_flags,
  output logic                    busy
);

  localparam int unsigned ACC_W  = DATA_WIDTH + LOG2_AVG;
  localparam int unsigned CNT_W  = LOG2_AVG + 1;
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  BLOCK_N   = CNT_W'(1 << LOG2_AVG);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    TIMER,
    REQ,
    WAIT_SAMPLE,
    EMIT
  } state_t;

  state_t                   state, state_next;
  logic [PERIOD_WIDTH-1:0]  timer;
  logic [WAIT_W-1:0]        wait_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_inc;
  logic [DATA_WIDTH-1:0]    blk_min, blk_max;
  logic [PERIOD_WIDTH-1:0]  timer_load;
  logic [ACC_W-1:0]         sample_ext;

  logic load_timer, accept, clr_block, set_timeout, emit, take;

  assign count_inc  = count + CNT_W'(1);
  assign timer_load = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
  assign sample_ext = {{LOG2_AVG{sample_in[DATA_WIDTH-1]}}, sample_in};
  // A new result may overwrite the held one only if it is empty or leaving now.
  assign take       = !avg_valid || avg_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_timer  = 1'b0;
    accept      = 1'b0;
    clr_block   = 1'b0;
    set_timeout = 1'b0;
    emit        = 1'b0;
    case (state)
      IDLE: begin
        clr_block = 1'b1;
        if (enable) begin
          state_next = TIMER;
          load_timer = 1'b1;
        end
      end
      TIMER: begin
        if (!enable) begin
          state_next = IDLE;
          clr_block  = 1'b1;
        end else if (timer == '0) begin
          state_next = REQ;
        end
      end
      REQ: state_next = WAIT_SAMPLE;
      WAIT_SAMPLE: begin
        if (sample_valid) begin
          accept = 1'b1;
          if (count_inc == BLOCK_N) begin
            state_next = EMIT;
          end else if (enable) begin
            state_next = TIMER;
            load_timer = 1'b1;
          end else begin
            state_next = IDLE;
            clr_block  = 1'b1;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          set_timeout = 1'b1;
          if (enable) begin
            state_next = TIMER;
            load_timer = 1'b1;
          end else begin
            state_next = IDLE;
            clr_block  = 1'b1;
          end
        end
      end
      EMIT: begin
        emit      = 1'b1;
        clr_block = 1'b1;
        if (enable) begin
          state_next = TIMER;
          load_timer = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Interval timer and sample-wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      wait_cnt <= '0;
    end else begin
      if (load_timer)
        timer <= timer_load;
      else if (state == TIMER && timer != '0)
        timer <= timer - PERIOD_WIDTH'(1);
      if (state == REQ)
        wait_cnt <= '0;
      else if (state == WAIT_SAMPLE && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Block accumulation with signed min/max tracking; clearing wins over accepting.
  always_ff @(posedge clk) begin
    if (rst || clr_block) begin
      acc     <= '0;
      count   <= '0;
      blk_min <= '0;
      blk_max <= '0;
    end else if (accept) begin
      acc   <= acc + $signed(sample_ext);
      count <= count_inc;
      if (count == '0) begin
        blk_min <= sample_in;
        blk_max <= sample_in;
      end else begin
        if ($signed(sample_in) < $signed(blk_min)) blk_min <= sample_in;
        if ($signed(sample_in) > $signed(blk_max)) blk_max <= sample_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      measure   <= 1'b0;
      busy      <= 1'b0;
      avg_data  <= '0;
      avg_min   <= '0;
      avg_max   <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      measure <= (state_next == REQ);
      busy    <= (state_next != IDLE);
      if (emit && take) begin
        avg_data  <= DATA_WIDTH'(acc >>> LOG2_AVG);
        avg_min   <= blk_min;
        avg_max   <= blk_max;
        avg_valid <= 1'b1;
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end
      if (emit && !take)    overrun <= 1'b1;
      else if (clear_flags) overrun <= 1'b0;
      if (set_timeout)      timeout <= 1'b1;
      else if (clear_flags) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ads1672_sample_averager.sv
// Directed bench for ads1672_sample_averager (4-sample blocks, 8-cycle timeout)
// with a simple ADC responder answering each measure after a set latency.
module tb_ads1672_sample_averager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd4;
  logic        measure;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [23:0] avg_data, avg_min, avg_max;
  logic        avg_valid;
  logic        avg_ready = 1'b1;
  logic        overrun, timeout;
  logic        clear_flags = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int adc_lat = 1;
  bit adc_on = 1'b1;
  logic [23:0] sq[$];
  int t0, t1;

  ads1672_sample_averager #(
    .DATA_WIDTH(24), .LOG2_AVG(2), .PERIOD_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .measure(measure),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .avg_data(avg_data), .avg_min(avg_min), .avg_max(avg_max),
    .avg_valid(avg_valid), .avg_ready(avg_ready),
    .overrun(overrun), .timeout(timeout), .clear_flags(clear_flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC responder: strobe the next queued sample adc_lat cycles after measure.
  initial begin
    forever begin
      @(negedge clk);
      if (measure && adc_on) begin
        repeat (adc_lat) @(negedge clk);
        sample_in    = (sq.size() > 0) ? sq.pop_front() : 24'd0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // which: 0 measure, 1 avg_valid, 2 overrun, 3 idle (busy low)
  task automatic wait_for(input int which, input int budget, input string tag, output int t);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = measure;
        1: hit = avg_valid;
        2: hit = overrun;
        3: hit = !busy;
        default: hit = 1'b1;
      endcase
    end
    t = cyc;
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic stop_and_idle(input string tag);
    enable = 1'b0;
    wait_for(3, 100, tag, t1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_measure"}, 32'(measure), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_valid"}, 32'(avg_valid), 32'd0);
    check({pfx, "_data"}, 32'(avg_data), 32'd0);
    check({pfx, "_overrun"}, 32'(overrun), 32'd0);
    check({pfx, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Pacing: period 4, sample strobe 5 cycles after measure -> 4+1+5 = 10 apart.
    period = 16'd4; adc_lat = 5; avg_ready = 1'b1;
    sq.push_back(24'd100); sq.push_back(24'd200);
    sq.push_back(24'd300); sq.push_back(24'd400);
    @(negedge clk); enable = 1'b1;
    wait_for(0, 50, "meas1_seen", t0);
    @(negedge clk);
    check("meas_width", 32'(measure), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
    wait_for(0, 50, "meas2_seen", t1);
    check("meas_spacing", 32'(t1 - t0), 32'd10);

    // Block of 100..400 -> 250, min 100, max 400; valid for one cycle.
    wait_for(1, 200, "blk1_valid", t1);
    check("blk1_data", 32'(avg_data), 32'd250);
    check("blk1_min", 32'(avg_min), 32'd100);
    check("blk1_max", 32'(avg_max), 32'd400);
    @(negedge clk);
    check("blk1_drop", 32'(avg_valid), 32'd0);
    stop_and_idle("idle1");

    // Negative block -1,-2,-2,-2: sum -7 floors to -2.
    period = 16'd1; adc_lat = 2;
    sq.push_back(24'hFFFFFF); sq.push_back(24'hFFFFFE);
    sq.push_back(24'hFFFFFE); sq.push_back(24'hFFFFFE);
    enable = 1'b1;
    wait_for(1, 200, "neg_valid", t1);
    check("neg_data", 32'(avg_data), 32'hFFFFFE);
    check("neg_min", 32'(avg_min), 32'hFFFFFE);
    check("neg_max", 32'(avg_max), 32'hFFFFFF);
    stop_and_idle("idle2");

    // Back-pressure: period 0 acts as 1 (spacing 1+1+1 = 3); second block overruns.
    period = 16'd0; adc_lat = 1; avg_ready = 1'b0;
    sq.push_back(24'd10);   sq.push_back(24'd20);
    sq.push_back(24'd30);   sq.push_back(24'd40);
    sq.push_back(24'd1000); sq.push_back(24'd2000);
    sq.push_back(24'd3000); sq.push_back(24'd4000);
    enable = 1'b1;
    wait_for(0, 50, "p0_meas1", t0);
    wait_for(0, 50, "p0_meas2", t1);
    check("p0_spacing", 32'(t1 - t0), 32'd3);
    wait_for(1, 200, "ovr_valid", t1);
    check("ovr_first", 32'(avg_data), 32'd25);
    wait_for(2, 200, "ovr_seen", t1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_held_data", 32'(avg_data), 32'd25);
    check("ovr_held_min", 32'(avg_min), 32'd10);
    check("ovr_held_max", 32'(avg_max), 32'd40);
    check("ovr_held_valid", 32'(avg_valid), 32'd1);
    stop_and_idle("idle3");
    clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_still_valid", 32'(avg_valid), 32'd1);
    avg_ready = 1'b1;
    @(negedge clk);
    check("ovr_transfer", 32'(avg_valid), 32'd0);

    // Timeout: no response for 8 wait cycles, then next measure after period 2.
    period = 16'd2; adc_on = 1'b0; adc_lat = 1;
    enable = 1'b1;
    wait_for(0, 50, "to_meas1", t0);
    repeat (8) @(negedge clk);
    check("to_not_yet", 32'(timeout), 32'd0);
    @(negedge clk);
    check("to_set", 32'(timeout), 32'd1);
    adc_on = 1'b1;
    sq.push_back(24'd4);  sq.push_back(24'd8);
    sq.push_back(24'd12); sq.push_back(24'd16);
    wait_for(0, 50, "to_meas2", t1);
    check("to_spacing", 32'(t1 - t0), 32'd11);
    wait_for(1, 200, "to_valid", t1);
    check("to_avg", 32'(avg_data), 32'd10);
    stop_and_idle("idle4");
    clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    check("to_cleared", 32'(timeout), 32'd0);

    // Reset after two samples discards them; next block is 7,7,7,11 -> 8.
    period = 16'd1; adc_lat = 1;
    sq.push_back(24'd500); sq.push_back(24'd600);
    enable = 1'b1;
    wait_for(0, 50, "rb_meas1", t0);
    wait_for(0, 50, "rb_meas2", t1);
    repeat (2) @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    sq.push_back(24'd7); sq.push_back(24'd7);
    sq.push_back(24'd7); sq.push_back(24'd11);
    enable = 1'b1;
    wait_for(1, 200, "rb_valid", t1);
    check("rb_data", 32'(avg_data), 32'd8);
    check("rb_min", 32'(avg_min), 32'd7);
    check("rb_max", 32'(avg_max), 32'd11);
    stop_and_idle("idle5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
